// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared instruction/data memory with a mem_ready stall handshake.
module riscv_multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    state_e     state_q, state_d;
    logic       illegal_op_q, illegal_op_d;
    logic       rdy;
    logic [2:0] alu_dec;
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;

    // Memory completion; a single-cycle memory is always ready.
    assign rdy = (MEM_HANDSHAKE == 1'b0) ? 1'b1 : mem_ready;

    // ALU operation from funct3; subtract only for R-type funct7b5.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = IMM_I;
        alu_ctrl      = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                adr_src      = 1'b0;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                alu_ctrl     = ALU_ADD;
                result_src   = RES_ALURES;
                ir_write_raw = rdy;
                pc_update    = rdy;
                if (rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                imm_src   = IMM_B;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                if (rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWRITE: begin
                // Strobe stays asserted for the whole stalled access.
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (rdy) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_ctrl  = alu_dec;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_ctrl  = alu_dec;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_ctrl   = ALU_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_ctrl   = ALU_ADD;
                result_src = RES_ALUOUT;
                imm_src    = IMM_J;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Write enables are held off while reset is asserted.
    assign pc_write  = rst_n & (pc_update | (branch & zero));
    assign ir_write  = rst_n & ir_write_raw;
    assign mem_write = rst_n & mem_write_raw;
    assign reg_write = rst_n & reg_write_raw;

    // Sticky flag: set on entry to TRAP, cleared only by reset.
    assign illegal_op_d = illegal_op_q | (state_d == S_TRAP);

    // State and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign illegal_op = illegal_op_q;
    assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: directed and random instruction streams
// checked per cycle against an instruction-level reference model.
module tb_riscv_multicycle_ctrl;

    typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_BAD} kind_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    riscv_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_ctrl(alu_ctrl), .reg_write(reg_write), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ALU operation an instruction needs, from its semantics.
    function automatic logic [2:0] alu_expect(logic [6:0] o, logic [2:0] f3, logic f7);
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b000 && o == OP_R && f7) return 3'b001;
        return 3'b000;
    endfunction

    // Expected output vector for one step of an instruction:
    // {state, pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b, imm_src, alu_ctrl, reg_write, illegal_op}
    function automatic logic [20:0] exp_vec(int st, logic rdy, logic zv);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; imm = 2'b00; alu = 3'b000;
        case (st)
            0:  begin sb = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin sa = 2'b01; sb = 2'b01; imm = 2'b10; end
            2:  begin sa = 2'b10; sb = 2'b01; imm = (op == OP_SW) ? 2'b01 : 2'b00; end
            3:  begin adr = 1'b1; end
            4:  begin res = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'b10; alu = alu_expect(op, funct3, funct7b5); end
            7:  begin sa = 2'b10; sb = 2'b01; alu = alu_expect(op, funct3, funct7b5); end
            8:  begin rw = 1'b1; end
            9:  begin sa = 2'b10; alu = 3'b001; pcw = zv; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; imm = 2'b11; end
            default: begin ill = 1'b1; end
        endcase
        return {4'(st), pcw, adr, mw, irw, res, sa, sb, imm, alu, rw, ill};
    endfunction

    task automatic check(string tag, logic [20:0] e);
        logic [20:0] a;
        a = {state_o, pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, imm_src, alu_ctrl, reg_write, illegal_op};
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, a, e);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, advance.
    task automatic step(int st, logic rdy, logic zv, string tag);
        mem_ready = rdy;
        zero      = zv;
        #1;
        check(tag, exp_vec(st, rdy, zv));
        @(negedge clk);
    endtask

    function automatic logic rbit();
        return 1'($urandom());
    endfunction

    // Run one instruction with sf fetch stalls and sm memory stalls.
    task automatic run_instr(kind_e k, logic [6:0] bad_op, logic [2:0] f3, logic f7,
                             logic zv, int sf, int sm);
        case (k)
            K_LW:    op = OP_LW;
            K_SW:    op = OP_SW;
            K_R:     op = OP_R;
            K_I:     op = OP_I;
            K_BEQ:   op = OP_BEQ;
            K_JAL:   op = OP_JAL;
            default: op = bad_op;
        endcase
        funct3   = f3;
        funct7b5 = f7;
        for (int i = 0; i < sf; i++) step(0, 1'b0, rbit(), "fetch_stall");
        step(0, 1'b1, rbit(), "fetch");
        step(1, rbit(), rbit(), "decode");
        case (k)
            K_LW: begin
                step(2, rbit(), rbit(), "lw_memadr");
                for (int i = 0; i < sm; i++) step(3, 1'b0, rbit(), "memread_stall");
                step(3, 1'b1, rbit(), "memread");
                step(4, rbit(), rbit(), "memwb");
            end
            K_SW: begin
                step(2, rbit(), rbit(), "sw_memadr");
                for (int i = 0; i < sm; i++) step(5, 1'b0, rbit(), "memwrite_stall");
                step(5, 1'b1, rbit(), "memwrite");
            end
            K_R: begin
                step(6, rbit(), rbit(), "execr");
                step(8, rbit(), rbit(), "aluwb_r");
            end
            K_I: begin
                step(7, rbit(), rbit(), "execi");
                step(8, rbit(), rbit(), "aluwb_i");
            end
            K_BEQ: step(9, rbit(), zv, "beq");
            K_JAL: begin
                step(10, rbit(), rbit(), "jal");
                step(8, rbit(), rbit(), "aluwb_jal");
            end
            default: for (int i = 0; i < 10; i++) step(11, rbit(), rbit(), "trap");
        endcase
    endtask

    // Assert reset for two cycles with mem_ready high; enables must stay low.
    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        #1;
        check("reset", exp_vec(0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        check("reset_hold", exp_vec(0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] bad_ops [4];
        bad_ops[0] = 7'b0001111; bad_ops[1] = 7'b1110011;
        bad_ops[2] = 7'b0110111; bad_ops[3] = 7'b1100111;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // lw with ready memory, then sw stalled 3 cycles in MEMWRITE
        run_instr(K_LW, 7'd0, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr(K_SW, 7'd0, 3'b010, 1'b0, 1'b0, 0, 3);
        // sub in EXECR vs addi with funct7b5 set
        run_instr(K_R, 7'd0, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(K_I, 7'd0, 3'b000, 1'b1, 1'b0, 0, 0);
        // beq taken and not taken
        run_instr(K_BEQ, 7'd0, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(K_BEQ, 7'd0, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(K_JAL, 7'd0, 3'b000, 1'b0, 1'b0, 0, 0);
        // fetch stalls and a stalled load
        run_instr(K_LW, 7'd0, 3'b010, 1'b0, 1'b0, 2, 2);

        // reset in the middle of a load aborts it
        op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0;
        step(0, 1'b1, 1'b0, "abort_fetch");
        step(1, 1'b1, 1'b0, "abort_decode");
        step(2, 1'b1, 1'b0, "abort_memadr");
        step(3, 1'b0, 1'b0, "abort_memread");
        do_reset();

        // randomized legal instruction stream
        for (int n = 0; n < 60; n++) begin
            run_instr(kind_e'($urandom_range(5, 0)), 7'd0, 3'($urandom_range(7, 0)),
                      rbit(), rbit(), $urandom_range(2, 0), $urandom_range(3, 0));
        end

        // unsupported opcode traps until reset, then execution resumes cleanly
        run_instr(K_BAD, 7'b0001111, 3'b000, 1'b0, 1'b0, 0, 0);
        do_reset();
        run_instr(K_R, 7'd0, 3'b111, 1'b0, 1'b0, 1, 0);
        run_instr(K_BAD, bad_ops[$urandom_range(3, 0)], 3'b000, 1'b0, 1'b0, 0, 0);
        do_reset();
        run_instr(K_I, 7'd0, 3'b110, 1'b0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
